// File: rtl/aes_pkg.sv
// Shared AES datapath types, MixColumns FSM state encoding and the GF(2^8) xtime helper.
package aes_pkg;

   typedef logic [7:0]  aes_byte_t;
   typedef logic [31:0] aes_col_t;

   localparam aes_byte_t AES_RED = 8'h1B;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } mc_state_t;

   function automatic aes_byte_t xtime(input aes_byte_t b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_RED : 8'h00);
   endfunction

endpackage

// File: rtl/mix_column_unit.sv
// One AES column through MixColumns (mode=0) or InvMixColumns (mode=1), purely combinational.
// Inverse coefficients are built only when MIXCOL_INV_EN is defined; otherwise mode is ignored.
module mix_column_unit
   import aes_pkg::*;
(
   input  logic [31:0] col,
   input  logic        mode,
   output logic [31:0] res
);

   // a[0] is row 0, the top byte of the column
   aes_byte_t [3:0] a;
   aes_byte_t [3:0] x2;
   aes_byte_t [3:0] fwd;

   assign a = {col[7:0], col[15:8], col[23:16], col[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_x2
      assign x2[i] = xtime(a[i]);
   end

   assign fwd[0] = x2[0] ^ x2[1] ^ a[1] ^ a[2] ^ a[3];
   assign fwd[1] = a[0] ^ x2[1] ^ x2[2] ^ a[2] ^ a[3];
   assign fwd[2] = a[0] ^ a[1] ^ x2[2] ^ x2[3] ^ a[3];
   assign fwd[3] = x2[0] ^ a[0] ^ a[1] ^ a[2] ^ x2[3];

`ifdef MIXCOL_INV_EN
   aes_byte_t [3:0] x4;
   aes_byte_t [3:0] x8;
   aes_byte_t [3:0] m9;
   aes_byte_t [3:0] mb;
   aes_byte_t [3:0] md;
   aes_byte_t [3:0] me;
   aes_byte_t [3:0] inv;

   for (genvar i = 0; i < 4; i++) begin : g_inv
      assign x4[i] = xtime(x2[i]);
      assign x8[i] = xtime(x4[i]);
      assign m9[i] = x8[i] ^ a[i];
      assign mb[i] = x8[i] ^ x2[i] ^ a[i];
      assign md[i] = x8[i] ^ x4[i] ^ a[i];
      assign me[i] = x8[i] ^ x4[i] ^ x2[i];
   end

   assign inv[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
   assign inv[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
   assign inv[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
   assign inv[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];

   always_comb begin
      res = {fwd[0], fwd[1], fwd[2], fwd[3]};
      if (mode) begin
         res = {inv[0], inv[1], inv[2], inv[3]};
      end
   end
`else
   logic unused_mode;
   assign unused_mode = mode;

   always_comb begin
      res = {fwd[0], fwd[1], fwd[2], fwd[3]};
   end
`endif

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns over a 128-bit state, COLS_PER_CYCLE (1/2/4) columns per BUSY cycle.
// Define MIXCOL_INV_EN to let in_inv select InvMixColumns; without it only the forward transform exists.
module mix_columns_seq
   import aes_pkg::*;
#(
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   localparam int unsigned STEPS = 4 / COLS_PER_CYCLE;
   localparam int unsigned SHIFT = 32 * COLS_PER_CYCLE;

   mc_state_t state;
   mc_state_t state_nx;
   logic [1:0]   col_cnt;
   logic [127:0] work;
   logic [127:0] work_nx;
   logic [127:0] result;
   logic         mode;
   logic         last;
   logic         accept;

   aes_col_t [COLS_PER_CYCLE-1:0] unit_out;

`ifdef MIXCOL_INV_EN
   logic inv_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inv_q <= 1'b0;
      end else if (accept) begin
         inv_q <= in_inv;
      end
   end

   assign mode = inv_q;
`else
   logic unused_inv;
   assign unused_inv = in_inv;
   assign mode       = 1'b0;
`endif

   for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_unit
      mix_column_unit u_col (
         .col  (work[32*k +: 32]),
         .mode (mode),
         .res  (unit_out[k])
      );
   end

   // The work register rotates: the lowest columns are transformed and re-enter at the top,
   // so after STEPS cycles every column is back at its original index.
   always_comb begin
      work_nx = work >> SHIFT;
      work_nx[127 -: SHIFT] = unit_out;
   end

   assign last = (col_cnt == 2'(STEPS - 1));

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nx = BUSY;
            end
         end
         BUSY: begin
            if (last) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               state_nx = in_valid ? BUSY : IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign accept   = in_valid && in_ready;
   assign out_data = result;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         col_cnt <= '0;
         work    <= '0;
         result  <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            work    <= in_data;
            col_cnt <= '0;
         end else if (state == BUSY) begin
            work    <= work_nx;
            col_cnt <= last ? 2'd0 : col_cnt + 2'd1;
            if (last) begin
               result <= work_nx;
            end
         end
      end
   end

endmodule
